// File: rtl/iicmb_cmd_tracker.sv
// Passive Wishbone command tracker for IICMB: snoops CSR/CMDR traffic and irq_i to report command lifecycle events.
// Optional timeout timer is built only when IICMB_CMD_TIMEOUT_EN is defined.
module iicmb_cmd_tracker #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     irq_i,
    input  logic                     cyc_o,
    input  logic                     stb_o,
    input  logic                     we_o,
    input  logic                     ack_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic [7:0]               csr_shadow,
    output logic                     cmd_active,
    output logic [2:0]               cmd_code,
    output logic                     cmd_done,
    output logic [3:0]               cmd_status,
    output logic [15:0]              cmd_count,
    output logic                     proto_err,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_IDLE,
        ST_BUSY,
        ST_IRQ_SEEN
    } state_e;

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    state_e      state_q, state_d;
    logic        irq_q;
    logic [7:0]  csr_shadow_q, csr_shadow_d;
    logic [2:0]  cmd_code_q, cmd_code_d;
    logic [3:0]  cmd_status_q, cmd_status_d;
    logic [15:0] cmd_count_q, cmd_count_d;
    logic        cmd_active_q, cmd_active_d;
    logic        cmd_done_q, cmd_done_d;
    logic        proto_err_q, proto_err_d;

    logic        wb_hs, csr_wr, cmdr_wr, cmdr_rd, wb_action;
    logic        irq_edge, rd_status_set;
    logic        start_cmd, complete_cmd, proto_evt, timeout_evt, timer_expired;
    logic        unused_bits;

    assign wb_hs         = cyc_o & stb_o & ack_i;
    assign csr_wr        = wb_hs & we_o & (adr_o == ADR_CSR);
    assign cmdr_wr       = wb_hs & we_o & (adr_o == ADR_CMDR);
    assign cmdr_rd       = wb_hs & ~we_o & (adr_o == ADR_CMDR);
    assign wb_action     = csr_wr | cmdr_wr | cmdr_rd;
    assign irq_edge      = irq_i & ~irq_q;
    assign rd_status_set = |dat_i[7:4];
    assign unused_bits   = ^{dat_i, dat_o, TIMEOUT_CYCLES[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_DISABLED;
            irq_q        <= 1'b0;
            csr_shadow_q <= '0;
            cmd_code_q   <= '0;
            cmd_status_q <= '0;
            cmd_count_q  <= '0;
            cmd_active_q <= 1'b0;
            cmd_done_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_i;
            csr_shadow_q <= csr_shadow_d;
            cmd_code_q   <= cmd_code_d;
            cmd_status_q <= cmd_status_d;
            cmd_count_q  <= cmd_count_d;
            cmd_active_q <= cmd_active_d;
            cmd_done_q   <= cmd_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Disable beats any handshake; a CSR/CMDR handshake masks an irq edge in the same cycle.
    always_comb begin
        state_d      = state_q;
        start_cmd    = 1'b0;
        complete_cmd = 1'b0;
        timeout_evt  = 1'b0;
        proto_evt    = cmdr_rd & dat_i[3];
        if (csr_wr && !dat_o[7]) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    if (csr_wr) begin
                        state_d = ST_IDLE;
                    end else if (cmdr_wr) begin
                        proto_evt = 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmdr_wr) begin
                        if (dat_o[2:0] != 3'b111) begin
                            state_d   = ST_BUSY;
                            start_cmd = 1'b1;
                        end else begin
                            proto_evt = 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cmdr_rd && rd_status_set) begin
                        state_d      = ST_IDLE;
                        complete_cmd = 1'b1;
                    end else begin
                        if (cmdr_wr) begin
                            proto_evt = 1'b1;
                        end
                        if (timer_expired) begin
                            state_d     = ST_IDLE;
                            timeout_evt = 1'b1;
                        end else if (irq_edge && !wb_action) begin
                            if (csr_shadow_q[6]) begin
                                state_d = ST_IRQ_SEEN;
                            end else begin
                                proto_evt = 1'b1;
                            end
                        end
                    end
                end
                ST_IRQ_SEEN: begin
                    if (cmdr_wr) begin
                        proto_evt = 1'b1;
                    end else if (cmdr_rd) begin
                        if (rd_status_set) begin
                            state_d      = ST_IDLE;
                            complete_cmd = 1'b1;
                        end else begin
                            proto_evt = 1'b1;
                        end
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    always_comb begin
        csr_shadow_d = csr_wr ? dat_o[7:0] : csr_shadow_q;
        cmd_code_d   = start_cmd ? dat_o[2:0] : cmd_code_q;
        cmd_status_d = complete_cmd ? dat_i[7:4] : cmd_status_q;
        cmd_count_d  = cmd_count_q;
        if (complete_cmd && (cmd_count_q != 16'hFFFF)) begin
            cmd_count_d = cmd_count_q + 16'd1;
        end
        cmd_active_d = (state_d == ST_BUSY) || (state_d == ST_IRQ_SEEN);
        cmd_done_d   = complete_cmd;
        proto_err_d  = proto_evt;
    end

`ifdef IICMB_CMD_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;

    assign timer_expired = (timer_q == TIMER_LAST);

    // Timer only advances while a command stays BUSY; it is frozen once the irq is seen.
    always_comb begin
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q | timeout_evt;
        if (start_cmd || (state_d == ST_DISABLED)) begin
            timer_d = '0;
        end else if ((state_q == ST_BUSY) && (state_d == ST_BUSY) && !timer_expired) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;

    assign timer_expired  = 1'b0;
    assign unused_timeout = timeout_evt;
    assign timeout_err    = 1'b0;
`endif

    assign csr_shadow = csr_shadow_q;
    assign cmd_active = cmd_active_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_done   = cmd_done_q;
    assign cmd_status = cmd_status_q;
    assign cmd_count  = cmd_count_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_iicmb_cmd_tracker.sv
// Self-checking bench for iicmb_cmd_tracker: directed scenarios with literal expectations plus
// randomized WB/irq traffic compared every cycle against a command-level model (honours IICMB_CMD_TIMEOUT_EN).
module tb_iicmb_cmd_tracker;

    localparam int TMO = 4096;

    logic        clk_i = 1'b0;
    logic        rst_i, irq_i, cyc_o, stb_o, we_o, ack_i;
    logic [1:0]  adr_o;
    logic [7:0]  dat_o, dat_i;
    logic [7:0]  csr_shadow;
    logic        cmd_active, cmd_done, proto_err, timeout_err;
    logic [2:0]  cmd_code;
    logic [3:0]  cmd_status;
    logic [15:0] cmd_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Model: enabled / outstanding / irq-acknowledged view of a command, plus elapsed BUSY cycles.
    bit          m_enabled, m_busy, m_irq_seen, m_timeout, m_irq_prev;
    bit          exp_done, exp_perr;
    int          m_elapsed;
    logic [7:0]  m_shadow;
    logic [2:0]  m_code;
    logic [3:0]  m_status;
    logic [15:0] m_count;

    iicmb_cmd_tracker #(
        .WB_ADDR_WIDTH (2),
        .WB_DATA_WIDTH (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .irq_i      (irq_i),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .ack_i      (ack_i),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .csr_shadow (csr_shadow),
        .cmd_active (cmd_active),
        .cmd_code   (cmd_code),
        .cmd_done   (cmd_done),
        .cmd_status (cmd_status),
        .cmd_count  (cmd_count),
        .proto_err  (proto_err),
        .timeout_err(timeout_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    // kind: 0 idle, 1 write, 2 read, 3 stalled cycle without ack. Returns one negedge later.
    task automatic applyStimulus(input int kind, input logic [1:0] adr, input logic [7:0] data);
        cyc_o = (kind != 0);
        stb_o = (kind != 0);
        ack_i = (kind == 1) || (kind == 2);
        we_o  = (kind == 1) || ((kind == 3) && $urandom_range(0, 1) == 1);
        adr_o = (kind == 0) ? 2'($urandom_range(0, 3)) : adr;
        dat_o = (kind == 2) ? 8'($urandom) : data;
        dat_i = (kind == 1) ? 8'($urandom) : data;
        if (kind == 0) begin
            dat_o = 8'($urandom);
            dat_i = 8'($urandom);
        end
        @(negedge clk_i);
        cyc_o = 1'b0;
        stb_o = 1'b0;
        ack_i = 1'b0;
        we_o  = 1'b0;
    endtask

    task automatic resetDut();
        irq_i = 1'b0;
        rst_i = 1'b1;
        applyStimulus(0, 2'd0, 8'h00);
        applyStimulus(0, 2'd0, 8'h00);
        rst_i = 1'b0;
    endtask

    always @(posedge clk_i) begin : model
        bit hs, csr_wr, cmdr_wr, cmdr_rd, irq_edge, handled, started, expire;
        logic [7:0] old_shadow;
        if (rst_i) begin
            m_enabled = 0; m_busy = 0; m_irq_seen = 0; m_timeout = 0; m_irq_prev = 0;
            exp_done = 0; exp_perr = 0; m_elapsed = 0;
            m_shadow = '0; m_code = '0; m_status = '0; m_count = '0;
        end else begin
            hs         = cyc_o && stb_o && ack_i;
            csr_wr     = hs && we_o && (adr_o == 2'd0);
            cmdr_wr    = hs && we_o && (adr_o == 2'd2);
            cmdr_rd    = hs && !we_o && (adr_o == 2'd2);
            handled    = csr_wr || cmdr_wr || cmdr_rd;
            irq_edge   = irq_i && !m_irq_prev;
            m_irq_prev = irq_i;
            old_shadow = m_shadow;
            exp_done   = 0;
            exp_perr   = cmdr_rd && dat_i[3];
            started    = 0;
            if (csr_wr) m_shadow = dat_o;
            if (csr_wr && !dat_o[7]) begin
                m_enabled = 0; m_busy = 0; m_irq_seen = 0; m_elapsed = 0;
            end else begin
                if (csr_wr) m_enabled = 1;
                if (cmdr_wr) begin
                    if (!m_enabled || m_busy || dat_o[2:0] == 3'b111) begin
                        exp_perr = 1;
                    end else begin
                        m_busy = 1; m_irq_seen = 0; m_code = dat_o[2:0]; m_elapsed = 0; started = 1;
                    end
                end
                if (cmdr_rd && m_busy) begin
                    if (dat_i[7:4] != 4'h0) begin
                        m_status = dat_i[7:4];
                        m_busy = 0; m_irq_seen = 0; exp_done = 1;
                        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                    end else if (m_irq_seen) begin
                        exp_perr = 1;
                    end
                end
                if (m_busy && !m_irq_seen && !started) begin
                    expire = 0;
`ifdef IICMB_CMD_TIMEOUT_EN
                    expire = (m_elapsed == TMO - 1);
`endif
                    if (expire) begin
                        m_timeout = 1;
                        m_busy = 0;
                    end else begin
                        m_elapsed++;
                        if (irq_edge && !handled) begin
                            if (old_shadow[6]) m_irq_seen = 1;
                            else exp_perr = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (check_en) begin
            checkOutput("csr_shadow",  32'(csr_shadow),  32'(m_shadow));
            checkOutput("cmd_active",  32'(cmd_active),  32'(m_busy));
            checkOutput("cmd_code",    32'(cmd_code),    32'(m_code));
            checkOutput("cmd_done",    32'(cmd_done),    32'(exp_done));
            checkOutput("cmd_status",  32'(cmd_status),  32'(m_status));
            checkOutput("cmd_count",   32'(cmd_count),   32'(m_count));
            checkOutput("proto_err",   32'(proto_err),   32'(exp_perr));
            checkOutput("timeout_err", 32'(timeout_err), 32'(m_timeout));
        end
    end

    initial begin
        int r;
        logic [7:0] d;
        rst_i = 1'b1; irq_i = 1'b0; cyc_o = 1'b0; stb_o = 1'b0; we_o = 1'b0; ack_i = 1'b0;
        adr_o = '0; dat_o = '0; dat_i = '0;
        @(negedge clk_i);
        check_en = 1'b1;
        checkOutput("reset_count", 32'(cmd_count), 32'h0);
        checkOutput("reset_active", 32'(cmd_active), 32'h0);
        resetDut();

        // Interrupt-driven completion
        applyStimulus(1, 2'd0, 8'hC0);
        applyStimulus(1, 2'd2, 8'h04);
        checkOutput("t1_active", 32'(cmd_active), 32'h1);
        checkOutput("t1_code", 32'(cmd_code), 32'h4);
        repeat (20) applyStimulus(0, 2'd0, 8'h00);
        irq_i = 1'b1;
        applyStimulus(0, 2'd0, 8'h00);
        checkOutput("t1_irq_perr", 32'(proto_err), 32'h0);
        applyStimulus(2, 2'd2, 8'h84);
        checkOutput("t1_done", 32'(cmd_done), 32'h1);
        checkOutput("t1_status", 32'(cmd_status), 32'h8);
        checkOutput("t1_count", 32'(cmd_count), 32'h1);
        checkOutput("t1_inactive", 32'(cmd_active), 32'h0);
        applyStimulus(0, 2'd0, 8'h00);
        checkOutput("t1_done_pulse", 32'(cmd_done), 32'h0);
        irq_i = 1'b0;

        // Polled completion with IE=0; irq edge is a violation
        resetDut();
        applyStimulus(1, 2'd0, 8'h80);
        applyStimulus(1, 2'd2, 8'h01);
        applyStimulus(2, 2'd2, 8'h01);
        checkOutput("t2_rd1_done", 32'(cmd_done), 32'h0);
        applyStimulus(2, 2'd2, 8'h01);
        checkOutput("t2_rd2_active", 32'(cmd_active), 32'h1);
        irq_i = 1'b1;
        applyStimulus(0, 2'd0, 8'h00);
        checkOutput("t2_irq_perr", 32'(proto_err), 32'h1);
        irq_i = 1'b0;
        applyStimulus(2, 2'd2, 8'hC1);
        checkOutput("t2_done", 32'(cmd_done), 32'h1);
        checkOutput("t2_status", 32'(cmd_status), 32'hC);

        // Reserved code and write while busy
        resetDut();
        applyStimulus(1, 2'd0, 8'hC0);
        applyStimulus(1, 2'd2, 8'h07);
        checkOutput("t3_code7_perr", 32'(proto_err), 32'h1);
        checkOutput("t3_code7_idle", 32'(cmd_active), 32'h0);
        applyStimulus(1, 2'd2, 8'h01);
        applyStimulus(1, 2'd2, 8'h02);
        checkOutput("t3_busy_wr_perr", 32'(proto_err), 32'h1);
        checkOutput("t3_code_kept", 32'(cmd_code), 32'h1);

        // Timeout
        resetDut();
        applyStimulus(1, 2'd0, 8'hC0);
        applyStimulus(1, 2'd2, 8'h05);
        repeat (TMO - 1) applyStimulus(0, 2'd0, 8'h00);
        checkOutput("t4_pre_timeout", 32'(timeout_err), 32'h0);
        applyStimulus(0, 2'd0, 8'h00);
`ifdef IICMB_CMD_TIMEOUT_EN
        checkOutput("t4_timeout", 32'(timeout_err), 32'h1);
        checkOutput("t4_inactive", 32'(cmd_active), 32'h0);
        repeat (5) applyStimulus(0, 2'd0, 8'h00);
        checkOutput("t4_sticky", 32'(timeout_err), 32'h1);
`else
        checkOutput("t4_no_timeout", 32'(timeout_err), 32'h0);
        checkOutput("t4_still_active", 32'(cmd_active), 32'h1);
`endif
        checkOutput("t4_count", 32'(cmd_count), 32'h0);

        // Abort by disable
        resetDut();
        applyStimulus(1, 2'd0, 8'hC0);
        applyStimulus(1, 2'd2, 8'h01);
        applyStimulus(1, 2'd0, 8'h00);
        checkOutput("t5_abort_active", 32'(cmd_active), 32'h0);
        checkOutput("t5_abort_done", 32'(cmd_done), 32'h0);
        applyStimulus(1, 2'd2, 8'h03);
        checkOutput("t5_disabled_perr", 32'(proto_err), 32'h1);

        // Reserved status bit on completion, then reset mid-command
        resetDut();
        applyStimulus(1, 2'd0, 8'hC0);
        applyStimulus(1, 2'd2, 8'h01);
        applyStimulus(2, 2'd2, 8'h88);
        checkOutput("t6_done", 32'(cmd_done), 32'h1);
        checkOutput("t6_status", 32'(cmd_status), 32'h8);
        checkOutput("t6_perr", 32'(proto_err), 32'h1);
        applyStimulus(1, 2'd2, 8'h02);
        rst_i = 1'b1;
        applyStimulus(0, 2'd0, 8'h00);
        rst_i = 1'b0;
        checkOutput("t6_rst_active", 32'(cmd_active), 32'h0);
        checkOutput("t6_rst_count", 32'(cmd_count), 32'h0);
        checkOutput("t6_rst_shadow", 32'(csr_shadow), 32'h0);
        checkOutput("t6_rst_code", 32'(cmd_code), 32'h0);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 9) == 0) irq_i = ~irq_i;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                rst_i = 1'b1;
                applyStimulus(0, 2'd0, 8'h00);
                rst_i = 1'b0;
            end else if (r < 20) begin
                case ($urandom_range(0, 3))
                    0: d = 8'hC0;
                    1: d = 8'h80;
                    2: d = 8'h40;
                    default: d = 8'hC0 | 8'($urandom_range(0, 63));
                endcase
                applyStimulus(1, 2'd0, d);
            end else if (r < 60) begin
                applyStimulus(1, 2'd2, 8'($urandom));
            end else if (r < 110) begin
                d = 8'($urandom);
                if ($urandom_range(0, 1) == 0) d[7:4] = 4'h0;
                if ($urandom_range(0, 3) != 0) d[3] = 1'b0;
                applyStimulus(2, 2'd2, d);
            end else if (r < 125) begin
                applyStimulus($urandom_range(1, 2), ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3, 8'($urandom));
            end else if (r < 140) begin
                applyStimulus(3, 2'($urandom_range(0, 3)), 8'($urandom));
            end else begin
                applyStimulus(0, 2'd0, 8'h00);
            end
        end

        check_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
